// File: rtl/user_gpio_pkg.sv
// Shared register map and sizing helper for the user-project GPIO controller.
package user_gpio_pkg;

   localparam logic [7:0] ADDR_DOUT     = 8'h00;
   localparam logic [7:0] ADDR_OE       = 8'h08;
   localparam logic [7:0] ADDR_DIN      = 8'h10;
   localparam logic [7:0] ADDR_RISE_EN  = 8'h18;
   localparam logic [7:0] ADDR_FALL_EN  = 8'h20;
   localparam logic [7:0] ADDR_IRQ_STAT = 8'h28;

   // Number of 32-bit words needed to cover n pads.
   function automatic int num_words(input int n);
      return (n + 31) / 32;
   endfunction

endpackage

// File: rtl/user_gpio_sync.sv
// Multi-flop synchroniser bringing the asynchronous pad inputs into the Wishbone clock domain.
module user_gpio_sync #(
   parameter int NUM_IO      = 38,
   parameter int SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [NUM_IO-1:0] io_in,
   output logic [NUM_IO-1:0] din
);

   logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IO-1:0] sync_d [SYNC_STAGES];

   always_comb begin
      sync_d[0] = io_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q <= sync_d;
      end
   end

   assign din = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/user_project_gpio_ctrl.sv
// Wishbone-slave GPIO controller: output data/enable registers, synchronised pad inputs and,
// when USER_GPIO_IRQ_EN is defined, per-pad rise/fall edge interrupts with W1C status.
module user_project_gpio_ctrl
   import user_gpio_pkg::*;
#(
   parameter int NUM_IO      = 38,
   parameter int SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_dat_i,
   input  logic [31:0]       wbs_adr_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic [NUM_IO-1:0] io_in,
   output logic [NUM_IO-1:0] io_out,
   output logic [NUM_IO-1:0] io_oeb,
   output logic              irq
);

   localparam int NUM_WORDS = num_words(NUM_IO);

   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;
   logic [NUM_IO-1:0] dout_q, dout_d;
   logic [NUM_IO-1:0] oe_q, oe_d;
   logic [NUM_IO-1:0] din;

   logic              access, wr_en, hi_half;
   logic [7:0]        reg_base;
   logic [31:0]       lane_mask, rd_data;
   logic [63:0]       wmask64, wdata64;
   logic [NUM_IO-1:0] wmask, wdata;
   logic              unused_bits;

   user_gpio_sync #(.NUM_IO(NUM_IO), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .io_in    (io_in),
      .din      (din)
   );

   function automatic logic [31:0] pick_half(input logic [63:0] v, input logic hi);
      return hi ? v[63:32] : v[31:0];
   endfunction

   // A transfer is decoded on the edge where ack rises; the idle cycle after ack keeps it single.
   assign access    = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign wr_en     = access & wbs_we_i;
   assign reg_base  = {wbs_adr_i[7:3], 3'b000};
   assign hi_half   = wbs_adr_i[2];
   assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign wmask64   = hi_half ? {lane_mask, 32'h0} : {32'h0, lane_mask};
   assign wdata64   = {wbs_dat_i, wbs_dat_i};
   assign wmask     = wmask64[NUM_IO-1:0];
   assign wdata     = wdata64[NUM_IO-1:0];
   assign unused_bits = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], wmask64, wdata64};

`ifdef USER_GPIO_IRQ_EN
   logic [NUM_IO-1:0] prev_q, prev_d;
   logic [NUM_IO-1:0] rise_en_q, rise_en_d;
   logic [NUM_IO-1:0] fall_en_q, fall_en_d;
   logic [NUM_IO-1:0] stat_q, stat_d;
   logic              irq_q, irq_d;
   logic [NUM_IO-1:0] edge_set, stat_clr;

   // Clearing first and then OR-ing new edges in makes a coincident edge win over the W1C.
   always_comb begin
      prev_d    = din;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      edge_set  = (din & ~prev_q & rise_en_q) | (~din & prev_q & fall_en_q);
      stat_clr  = '0;
      if (wr_en && reg_base == ADDR_RISE_EN) rise_en_d = (rise_en_q & ~wmask) | (wdata & wmask);
      if (wr_en && reg_base == ADDR_FALL_EN) fall_en_d = (fall_en_q & ~wmask) | (wdata & wmask);
      if (wr_en && reg_base == ADDR_IRQ_STAT) stat_clr = wdata & wmask;
      stat_d = (stat_q & ~stat_clr) | edge_set;
      irq_d  = |stat_d;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         prev_q    <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         stat_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         stat_q    <= stat_d;
         irq_q     <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      dout_d  = dout_q;
      oe_d    = oe_q;
      rd_data = '0;
      if (wr_en && reg_base == ADDR_DOUT) dout_d = (dout_q & ~wmask) | (wdata & wmask);
      if (wr_en && reg_base == ADDR_OE)   oe_d   = (oe_q & ~wmask) | (wdata & wmask);
      case (reg_base)
         ADDR_DOUT:     rd_data = pick_half(64'(dout_q), hi_half);
         ADDR_OE:       rd_data = pick_half(64'(oe_q), hi_half);
         ADDR_DIN:      rd_data = pick_half(64'(din), hi_half);
`ifdef USER_GPIO_IRQ_EN
         ADDR_RISE_EN:  rd_data = pick_half(64'(rise_en_q), hi_half);
         ADDR_FALL_EN:  rd_data = pick_half(64'(fall_en_q), hi_half);
         ADDR_IRQ_STAT: rd_data = pick_half(64'(stat_q), hi_half);
`endif
         default:       rd_data = '0;
      endcase
      if (hi_half && NUM_WORDS < 2) rd_data = '0;
      ack_d = access;
      dat_d = (access && !wbs_we_i) ? rd_data : 32'h0;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q  <= 1'b0;
         dat_q  <= '0;
         dout_q <= '0;
         oe_q   <= '0;
      end else begin
         ack_q  <= ack_d;
         dat_q  <= dat_d;
         dout_q <= dout_d;
         oe_q   <= oe_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign io_out    = dout_q;
   assign io_oeb    = ~oe_q;

endmodule

// File: tb/tb_user_project_gpio_ctrl.sv
// Directed bench for user_project_gpio_ctrl: bus handshake, register map, reset, input
// synchroniser latency and (with USER_GPIO_IRQ_EN) edge interrupts.
module tb_user_project_gpio_ctrl;

   localparam int NUM_IO      = 38;
   localparam int SYNC_STAGES = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              stb, cyc, we;
   logic [3:0]        sel;
   logic [31:0]       datIn, adr;
   logic              ack;
   logic [31:0]       datOut;
   logic [NUM_IO-1:0] ioIn, ioOut, ioOeb;
   logic              irq;
   logic [31:0]       rd;

   int testCount = 0;
   int failCount = 0;

   user_project_gpio_ctrl #(.NUM_IO(NUM_IO), .SYNC_STAGES(SYNC_STAGES)) dut (
      .wb_clk_i  (clock),
      .wb_rst_i  (reset),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (datIn),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (datOut),
      .io_in     (ioIn),
      .io_out    (ioOut),
      .io_oeb    (ioOeb),
      .irq       (irq)
   );

   // 100 MHz clock
   always #5 clock = ~clock;

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One Wishbone transfer, started just after a rising edge; ack latency and drop are checked
   task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] byteSel,
                                output logic [31:0] rdata);
      int waitCycles;
      cyc   = 1'b1;
      stb   = 1'b1;
      we    = wr;
      adr   = addr;
      datIn = data;
      sel   = byteSel;
      waitCycles = 0;
      do begin
         @(posedge clock); #1;
         waitCycles++;
      end while (ack !== 1'b1 && waitCycles < 8);
      checkOutput({tag, "_ackLatency"}, 64'(waitCycles), 64'd1);
      rdata = datOut;
      cyc   = 1'b0;
      stb   = 1'b0;
      we    = 1'b0;
      datIn = '0;
      sel   = '0;
      @(posedge clock); #1;
      checkOutput({tag, "_ackDrop"}, {62'b0, ack, |datOut}, 64'd0);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clock); #1;
      end
   endtask

   // Hard time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence with hand-computed expectations
   initial begin
      reset = 1'b1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; datIn = '0; adr = '0;
      ioIn = '0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rstOeb", 64'(ioOeb), 64'h3F_FFFF_FFFF);
      checkOutput("rstOut", 64'(ioOut), 64'h0);
      checkOutput("rstAck", 64'(ack), 64'h0);
      checkOutput("rstDat", 64'(datOut), 64'h0);
      checkOutput("rstIrq", 64'(irq), 64'h0);
      reset = 1'b0;
      idleCycles(1);

      applyStimulus("oeLoInit", 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, rd);
      applyStimulus("oeHiInit", 1'b1, 32'h0C, 32'hFFFF_FFFF, 4'hF, rd);
      applyStimulus("doutInit", 1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, rd);
      checkOutput("oeAllDrive", 64'(ioOeb), 64'h0);
      checkOutput("doutLoInit", 64'(ioOut), 64'h00_FFFF_FFFF);

      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h04; datIn = 32'hFFFF_FFFF; sel = 4'hF;
      @(posedge clock); #1;
      checkOutput("midAckHigh", 64'(ack), 64'h1);
      #2 reset = 1'b1;
      #1;
      checkOutput("midRstAck", 64'(ack), 64'h0);
      checkOutput("midRstDat", 64'(datOut), 64'h0);
      checkOutput("midRstOeb", 64'(ioOeb), 64'h3F_FFFF_FFFF);
      checkOutput("midRstOut", 64'(ioOut), 64'h0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; datIn = '0;
      @(posedge clock); #1;
      reset = 1'b0;
      idleCycles(1);

      applyStimulus("byteWr", 1'b1, 32'h00, 32'hA5A5_5AA5, 4'b0101, rd);
      checkOutput("byteMaskOut", 64'(ioOut), 64'h00_00A5_00A5);
      applyStimulus("byteRd", 1'b0, 32'h00, 32'h0, 4'hF, rd);
      checkOutput("byteMaskRd", 64'(rd), 64'h00A5_00A5);

      applyStimulus("doutHiWr", 1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, rd);
      checkOutput("doutHiOut", 64'(ioOut), 64'h3F_00A5_00A5);
      applyStimulus("doutHiRd", 1'b0, 32'h04, 32'h0, 4'hF, rd);
      checkOutput("doutHiRdVal", 64'(rd), 64'h0000_003F);

      applyStimulus("oeHiWr", 1'b1, 32'h0C, 32'hFFFF_FFFF, 4'hF, rd);
      checkOutput("oeHiOeb", 64'(ioOeb), 64'h00_FFFF_FFFF);
      applyStimulus("oeHiRd", 1'b0, 32'h0C, 32'h0, 4'hF, rd);
      checkOutput("oeHiRdVal", 64'(rd), 64'h0000_003F);

      applyStimulus("oeLoWr", 1'b1, 32'h08, 32'h1234_FF00, 4'b0010, rd);
      checkOutput("oeLoOeb", 64'(ioOeb), 64'h00_FFFF_00FF);
      applyStimulus("oeLoRd", 1'b0, 32'h08, 32'h0, 4'hF, rd);
      checkOutput("oeLoRdVal", 64'(rd), 64'h0000_FF00);

      applyStimulus("dinRoWr", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, rd);
      applyStimulus("dinRoRd", 1'b0, 32'h10, 32'h0, 4'hF, rd);
      checkOutput("dinRoVal", 64'(rd), 64'h0);

      ioIn[33] = 1'b1;
      idleCycles(1);
      applyStimulus("dinEarlyRd", 1'b0, 32'h14, 32'h0, 4'hF, rd);
      checkOutput("dinEarly", 64'(rd), 64'h0);
      ioIn[34] = 1'b1;
      idleCycles(SYNC_STAGES);
      applyStimulus("dinLateRd", 1'b0, 32'h14, 32'h0, 4'hF, rd);
      checkOutput("dinLate", 64'(rd), 64'h6);

      applyStimulus("unmapRd", 1'b0, 32'h40, 32'h0, 4'hF, rd);
      checkOutput("unmapRdVal", 64'(rd), 64'h0);
      applyStimulus("unmapWr", 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, rd);
      applyStimulus("unmapDoutRd", 1'b0, 32'h00, 32'h0, 4'hF, rd);
      checkOutput("unmapNoEffect", 64'(rd), 64'h00A5_00A5);

`ifdef USER_GPIO_IRQ_EN
      checkOutput("irqIdle", 64'(irq), 64'h0);
      applyStimulus("riseEnWr", 1'b1, 32'h18, 32'h0000_0008, 4'hF, rd);
      applyStimulus("riseEnRd", 1'b0, 32'h18, 32'h0, 4'hF, rd);
      checkOutput("riseEnVal", 64'(rd), 64'h8);
      ioIn[3] = 1'b1;
      idleCycles(4);
      ioIn[3] = 1'b0;
      checkOutput("irqRise", 64'(irq), 64'h1);
      applyStimulus("statRd", 1'b0, 32'h28, 32'h0, 4'hF, rd);
      checkOutput("statVal", 64'(rd), 64'h8);
      idleCycles(4);
      checkOutput("irqSticky", 64'(irq), 64'h1);
      applyStimulus("w1cWr", 1'b1, 32'h28, 32'h0000_0008, 4'hF, rd);
      checkOutput("irqCleared", 64'(irq), 64'h0);
      applyStimulus("statClrRd", 1'b0, 32'h28, 32'h0, 4'hF, rd);
      checkOutput("statClrVal", 64'(rd), 64'h0);
      ioIn[3] = 1'b1;
      idleCycles(SYNC_STAGES);
      applyStimulus("coincW1c", 1'b1, 32'h28, 32'h0000_0008, 4'hF, rd);
      checkOutput("irqSetWins", 64'(irq), 64'h1);
      applyStimulus("coincStatRd", 1'b0, 32'h28, 32'h0, 4'hF, rd);
      checkOutput("coincStat", 64'(rd), 64'h8);
`else
      applyStimulus("riseEnWr", 1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF, rd);
      applyStimulus("riseEnRd", 1'b0, 32'h18, 32'h0, 4'hF, rd);
      checkOutput("riseEnUnmapped", 64'(rd), 64'h0);
      ioIn[3] = 1'b1;
      idleCycles(4);
      checkOutput("irqTiedLow", 64'(irq), 64'h0);
      applyStimulus("statRd", 1'b0, 32'h28, 32'h0, 4'hF, rd);
      checkOutput("statUnmapped", 64'(rd), 64'h0);
      applyStimulus("doutAfterIrqRd", 1'b0, 32'h00, 32'h0, 4'hF, rd);
      checkOutput("doutAfterIrq", 64'(rd), 64'h00A5_00A5);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
